// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-requester memory arbiter.
package mem_arb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  // 2-way round robin: a lone requester wins, a tie goes to the one not granted last.
  function automatic logic rr_pick(input logic [1:0] req, input logic last_grant);
    logic pick;
    pick = last_grant;
    case (req)
      2'b01:   pick = REQ_A;
      2'b10:   pick = REQ_B;
      2'b11:   pick = ~last_grant;
      default: pick = last_grant;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick; req[0] is requester A, req[1] is requester B.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant
);

  assign grant = rr_pick(req, last_grant);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters onto one single-port memory and returns read data
// to whichever requester owned the access.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int READ_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_done,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_done,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_mode,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [2:0] LAT_C = 3'(READ_LAT);

  state_t            state_r;
  req_id_t           last_grant_r;
  req_id_t           owner_r;
  logic              we_r;
  logic [2:0]        cnt_r;
  logic              mem_mode_r;
  logic              mem_we_r;
  logic [1:0]        req_s;
  logic              win_s;
  logic              sel_we_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;

  assign req_s = {b_req, a_req};

  rr_arbiter2 u_rr (
    .req        (req_s),
    .last_grant (last_grant_r),
    .grant      (win_s)
  );

  // Command fields of the requester that wins this cycle's arbitration.
  always_comb begin
    sel_we_s    = a_we;
    sel_addr_s  = a_addr;
    sel_wdata_s = a_wdata;
    if (win_s == REQ_B) begin
      sel_we_s    = b_we;
      sel_addr_s  = b_addr;
      sel_wdata_s = b_wdata;
    end else begin
      sel_we_s    = a_we;
      sel_addr_s  = a_addr;
      sel_wdata_s = a_wdata;
    end
  end

  // Strobes are forced low while reset is asserted, not just after the edge.
  assign mem_mode = mem_mode_r & ~reset;
  assign mem_we   = mem_we_r & ~reset;

  // Transaction FSM with registered handshake and memory command outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      last_grant_r <= REQ_B;
      owner_r      <= REQ_A;
      we_r         <= 1'b0;
      cnt_r        <= 3'd0;
      mem_mode_r   <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      a_gnt        <= 1'b0;
      b_gnt        <= 1'b0;
      a_done       <= 1'b0;
      b_done       <= 1'b0;
      a_rdata      <= '0;
      b_rdata      <= '0;
      busy         <= 1'b0;
    end else begin
      a_gnt      <= 1'b0;
      b_gnt      <= 1'b0;
      a_done     <= 1'b0;
      b_done     <= 1'b0;
      mem_mode_r <= 1'b0;
      mem_we_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (|req_s) begin
            owner_r      <= req_id_t'(win_s);
            last_grant_r <= req_id_t'(win_s);
            we_r         <= sel_we_s;
            mem_addr     <= sel_addr_s;
            mem_wdata    <= sel_wdata_s;
            mem_mode_r   <= 1'b1;
            mem_we_r     <= sel_we_s;
            a_gnt        <= (win_s == REQ_A);
            b_gnt        <= (win_s == REQ_B);
            busy         <= 1'b1;
            state_r      <= ST_ISSUE;
          end else begin
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (we_r) begin
            a_done  <= (owner_r == REQ_A);
            b_done  <= (owner_r == REQ_B);
            state_r <= ST_DONE;
          end else begin
            cnt_r   <= 3'd1;
            state_r <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          // cnt_r numbers the RD_WAIT cycles 1..READ_LAT; data is valid in the last one.
          if (cnt_r == LAT_C) begin
            if (owner_r == REQ_B) begin
              b_rdata <= mem_rdata;
            end else begin
              a_rdata <= mem_rdata;
            end
            a_done  <= (owner_r == REQ_A);
            b_done  <= (owner_r == REQ_B);
            cnt_r   <= 3'd0;
            state_r <= ST_DONE;
          end else begin
            cnt_r   <= cnt_r + 3'd1;
            state_r <= ST_RD_WAIT;
          end
        end
        ST_DONE: begin
          busy    <= 1'b0;
          cnt_r   <= 3'd0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          cnt_r   <= 3'd0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a resettable behavioural memory of READ_LAT latency.
module tb_mem_arbiter;

  localparam int DW       = 32;
  localparam int AW       = 5;
  localparam int READ_LAT = 2;

  logic          clk;
  logic          reset;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, a_done, b_gnt, b_done;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          mem_mode, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .READ_LAT(READ_LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_gnt     (a_gnt),
    .a_done    (a_done),
    .a_rdata   (a_rdata),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_gnt     (b_gnt),
    .b_done    (b_done),
    .b_rdata   (b_rdata),
    .mem_mode  (mem_mode),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: read data appears READ_LAT cycles after the issue edge, zero otherwise.
  logic [DW-1:0] mem  [0:(1<<AW)-1];
  logic [DW-1:0] pipe [0:READ_LAT-1];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < (1<<AW); i++) mem[i] <= '0;
      for (int i = 0; i < READ_LAT; i++) pipe[i] <= '0;
    end else begin
      if (mem_mode && mem_we) mem[mem_addr] <= mem_wdata;
      pipe[0] <= (mem_mode && !mem_we) ? mem[mem_addr] : 32'h0;
      for (int i = 1; i < READ_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign mem_rdata = pipe[READ_LAT-1];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Grants must be exclusive every cycle; strobes must be low whenever reset is high.
  always @(negedge clk) begin
    check_eq("gnt_excl", {31'b0, a_gnt & b_gnt}, 32'd0);
    if (reset) begin
      check_eq("rst_mode", {31'b0, mem_mode}, 32'd0);
      check_eq("rst_we", {31'b0, mem_we}, 32'd0);
    end
  end

  // One full transaction, starting in IDLE with the requester's inputs already driven.
  task automatic txn(input logic wb, input logic we, input logic [AW-1:0] addr,
                     input logic [DW-1:0] wdata, input logic drop,
                     input logic [DW-1:0] exp_own, input logic [DW-1:0] exp_oth);
    tick();
    check_eq("gnt_win", {31'b0, wb ? b_gnt : a_gnt}, 32'd1);
    check_eq("gnt_lose", {31'b0, wb ? a_gnt : b_gnt}, 32'd0);
    check_eq("issue_mode", {31'b0, mem_mode}, 32'd1);
    check_eq("issue_we", {31'b0, mem_we}, {31'b0, we});
    check_eq("issue_addr", {27'b0, mem_addr}, {27'b0, addr});
    check_eq("issue_wdata", mem_wdata, wdata);
    check_eq("issue_busy", {31'b0, busy}, 32'd1);
    if (drop) begin
      if (wb) b_req = 1'b0;
      else    a_req = 1'b0;
    end
    if (!we) begin
      for (int i = 0; i < READ_LAT; i++) begin
        tick();
        check_eq("wait_done", {31'b0, a_done | b_done}, 32'd0);
        check_eq("wait_mode", {31'b0, mem_mode | mem_we}, 32'd0);
        check_eq("wait_addr", {27'b0, mem_addr}, {27'b0, addr});
        check_eq("wait_busy", {31'b0, busy}, 32'd1);
      end
    end
    tick();
    check_eq("done_own", {31'b0, wb ? b_done : a_done}, 32'd1);
    check_eq("done_oth", {31'b0, wb ? a_done : b_done}, 32'd0);
    check_eq("done_mode", {31'b0, mem_mode}, 32'd0);
    check_eq("rdata_own", wb ? b_rdata : a_rdata, exp_own);
    check_eq("rdata_oth", wb ? a_rdata : b_rdata, exp_oth);
    tick();
    check_eq("idle_busy", {31'b0, busy}, 32'd0);
    check_eq("idle_done", {31'b0, a_done | b_done}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    tick();
    tick();
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_gnt", {30'b0, a_gnt, b_gnt}, 32'd0);
    check_eq("rst_done", {30'b0, a_done, b_done}, 32'd0);
    check_eq("rst_a_rdata", a_rdata, 32'd0);
    check_eq("rst_b_rdata", b_rdata, 32'd0);
    check_eq("rst_mem_addr", {27'b0, mem_addr}, 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    reset = 1'b0;

    // A writes 5 = DEADBEEF, then reads it back; req dropped after each grant.
    a_we = 1'b1; a_addr = 5'd5; a_wdata = 32'hDEADBEEF; a_req = 1'b1;
    txn(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 32'h0, 32'h0);
    a_we = 1'b0; a_req = 1'b1;
    txn(1'b0, 1'b0, 5'd5, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 32'h0);

    // Both requesters rise together after reset: strict A,B alternation, 4 writes each.
    do_reset();
    a_we = 1'b1; a_addr = 5'd10; a_wdata = 32'hAAAA0001;
    b_we = 1'b1; b_addr = 5'd11; b_wdata = 32'hBBBB0002;
    a_req = 1'b1; b_req = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 1)
        txn(1'b1, 1'b1, 5'd11, 32'hBBBB0002, (k >= 6), 32'h0, 32'h0);
      else
        txn(1'b0, 1'b1, 5'd10, 32'hAAAA0001, (k >= 6), 32'h0, 32'h0);
    end

    // Address extremes and rdata isolation between requesters.
    b_we = 1'b1; b_addr = 5'd31; b_wdata = 32'h00000001; b_req = 1'b1;
    txn(1'b1, 1'b1, 5'd31, 32'h00000001, 1'b1, 32'h0, 32'h0);
    a_we = 1'b1; a_addr = 5'd0; a_wdata = 32'hFFFFFFFF; a_req = 1'b1;
    txn(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 32'h0, 32'h0);
    a_we = 1'b0; a_addr = 5'd31; a_req = 1'b1;
    txn(1'b0, 1'b0, 5'd31, 32'hFFFFFFFF, 1'b1, 32'h00000001, 32'h0);
    b_we = 1'b0; b_addr = 5'd0; b_req = 1'b1;
    txn(1'b1, 1'b0, 5'd0, 32'h00000001, 1'b1, 32'hFFFFFFFF, 32'h00000001);
    a_we = 1'b1; a_addr = 5'd7; a_wdata = 32'h12345678; a_req = 1'b1;
    txn(1'b0, 1'b1, 5'd7, 32'h12345678, 1'b1, 32'h00000001, 32'hFFFFFFFF);

    // Reset in the first RD_WAIT cycle of a read of 7 aborts it silently.
    a_we = 1'b0; a_addr = 5'd7; a_req = 1'b1;
    tick();
    check_eq("abort_gnt", {31'b0, a_gnt}, 32'd1);
    a_req = 1'b0;
    tick();
    check_eq("abort_wait_busy", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("abort_busy", {31'b0, busy}, 32'd0);
    check_eq("abort_a_rdata", a_rdata, 32'd0);
    check_eq("abort_mem_addr", {27'b0, mem_addr}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("abort_no_done", {31'b0, a_done | b_done}, 32'd0);
      check_eq("abort_idle", {31'b0, busy}, 32'd0);
      check_eq("abort_rdata_hold", a_rdata, 32'd0);
    end
    a_req = 1'b1;
    txn(1'b0, 1'b0, 5'd7, 32'h12345678, 1'b1, 32'h0, 32'h0);

    // A alone, req held over three writes: back-to-back every 3 cycles.
    a_we = 1'b1; a_addr = 5'd20; a_wdata = 32'h0F0F0F0F; a_req = 1'b1;
    txn(1'b0, 1'b1, 5'd20, 32'h0F0F0F0F, 1'b0, 32'h0, 32'h0);
    txn(1'b0, 1'b1, 5'd20, 32'h0F0F0F0F, 1'b0, 32'h0, 32'h0);
    txn(1'b0, 1'b1, 5'd20, 32'h0F0F0F0F, 1'b1, 32'h0, 32'h0);
    tick();
    check_eq("final_idle", {31'b0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, memory word width.
REQ-002 SHALL have parameter ADDR_W, default 5, memory address width (32 words).
REQ-003 SHALL have parameter READ_LAT, default 2, range 1-7, cycles from the issue edge to valid mem_rdata.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports a_req/b_req  in  1  requester wants one access; held until its done.
REQ-007 SHALL have ports a_we/b_we  in  1  1=write, 0=read; sampled at grant.
REQ-008 SHALL have ports a_addr/b_addr  in  ADDR_W  target word; sampled at grant.
REQ-009 SHALL have ports a_wdata/b_wdata  in  DATA_W  write data; sampled at grant.
REQ-010 SHALL have ports a_gnt/b_gnt  out  1  one-cycle pulse; command accepted.
REQ-011 SHALL have ports a_done/b_done  out  1  one-cycle pulse; access complete.
REQ-012 SHALL have ports a_rdata/b_rdata  out  DATA_W  last read result per requester.
REQ-013 SHALL have ports mem_mode, mem_we  out  1  memory access strobe and write enable.
REQ-014 SHALL have ports mem_addr  out  ADDR_W and mem_wdata  out  DATA_W  memory command.
REQ-015 SHALL have port mem_rdata  in  DATA_W  memory read data.
REQ-016 SHALL have port busy  out  1  high in every non-IDLE state.

Function
REQ-017 SHALL implement FSM IDLE, ISSUE, RD_WAIT, DONE.
REQ-018 IDLE: no req -> stay; otherwise at the edge latch winner id, we, addr, wdata, and go to ISSUE.
REQ-019 Arbitration: single requester wins; if both request, the one not granted last wins (2-way round robin).
REQ-020 last_grant SHALL update only on a grant; reset value = B, so A wins the first tie.
REQ-021 Winner's gnt SHALL be high for exactly the ISSUE cycle; never both gnt high.
REQ-022 ISSUE (1 cycle): mem_mode=1, mem_we=latched we, mem_addr/mem_wdata = latched values.
REQ-023 ISSUE -> DONE for writes; ISSUE -> RD_WAIT for reads.
REQ-024 RD_WAIT SHALL last READ_LAT cycles (3-bit counter), with mem_addr held and mem_mode/mem_we=0.
REQ-025 At the edge ending the last RD_WAIT cycle, mem_rdata SHALL be captured into the owner's rdata; the other rdata is unchanged.
REQ-026 DONE (1 cycle): owner's done=1, then IDLE.
REQ-027 Writes SHALL leave both rdata registers unchanged.
REQ-028 Latency from the req-sampling edge: write done in cycle 2, read done in cycle 2+READ_LAT; minimum period 3 cycles (write) or 3+READ_LAT cycles (read).
REQ-029 Dropping req after gnt SHALL NOT cancel the access; req still high in IDLE after DONE SHALL start a new transaction.
REQ-030 Outside ISSUE: mem_mode=0 and mem_we=0; mem_addr/mem_wdata hold their last values.
REQ-031 Addresses 0 and 2^ADDR_W-1 SHALL be passed unmodified; there is no address arithmetic.

Reset
REQ-032 With reset high at an edge: state=IDLE, last_grant=B, gnt/done=0, rdata=0, mem_* outputs=0, busy=0, counter=0.
REQ-033 Reset SHALL override any in-flight transaction with no done pulse; an in-flight read result is discarded.
REQ-034 mem_mode and mem_we SHALL be 0 in any cycle where reset is high.

Structure
REQ-035 The shared package mem_arb_pkg SHALL hold the state enum, requester-id type, and default DATA_W/ADDR_W constants.
REQ-036 The 2-way round-robin pick SHALL be sub-module rr_arbiter2 (inputs req[1:0], last_grant; output grant id), and the memory SHALL be instantiated outside this block.

Verification
REQ-037 After reset, A writes addr 5 = 0xDEADBEEF: a_gnt, mem_mode=1, mem_we=1, mem_addr=5 in the same cycle; a_done next cycle; then A reads 5 -> a_rdata=0xDEADBEEF with a_done at cycle 2+READ_LAT.
REQ-038 a_req and b_req rise together after reset, held 4 transactions each: grant order A,B,A,B,...; never both gnt.
REQ-039 B writes addr 31 = 0x00000001, A writes addr 0 = 0xFFFFFFFF; A reads 31 -> 0x00000001, B reads 0 -> 0xFFFFFFFF; each rdata is unchanged by the other's access.
REQ-040 Reset pulsed during RD_WAIT: next cycle IDLE, busy=0, no a_done, a_rdata=0; a later read of the previously written address returns 0 (memory cleared by the shared reset).
REQ-041 Only A requesting, req held, 3 writes: a_gnt every 3 cycles, b_gnt never, busy low exactly one cycle between transactions.
